// File: rtl/i2c_pkg.sv
// Shared I2C responder types and constants; also imported by the bench-side I2C agent.
package i2c_pkg;

   localparam int I2C_ADDR_W = 7;
   localparam int I2C_DATA_W = 8;

   // R/W bit carried in bit 0 of the address byte
   localparam logic I2C_RW_WRITE = 1'b0;
   localparam logic I2C_RW_READ  = 1'b1;

   // Cycles the read path waits for rd_valid before sending 8'hFF
   localparam int RD_TIMEOUT = 4;

   typedef enum logic [3:0] {
      IDLE,
      ADDR,
      ADDR_ACK,
      WR_BYTE,
      WR_ACK,
      RD_LOAD,
      RD_BYTE,
      RD_ACK,
      IGNORE
   } i2c_resp_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers plus SCL edge and START/STOP condition detection.
module i2c_bus_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_s,
   output logic sda_s,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop
);

   logic [SYNC_STAGES-1:0] scl_sync_q;
   logic [SYNC_STAGES-1:0] sda_sync_q;
   logic                   scl_hist_q;
   logic                   sda_hist_q;

   // Reset to the idle-bus level so leaving reset never fakes an edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
         scl_hist_q <= 1'b1;
         sda_hist_q <= 1'b1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
         scl_hist_q <= scl_s;
         sda_hist_q <= sda_s;
      end
   end

   assign scl_s    = scl_sync_q[SYNC_STAGES-1];
   assign sda_s    = sda_sync_q[SYNC_STAGES-1];
   assign scl_rise = scl_s & ~scl_hist_q;
   assign scl_fall = ~scl_s & scl_hist_q;
   assign start    = scl_s & scl_hist_q & sda_hist_q & ~sda_s;
   assign stop     = scl_s & scl_hist_q & ~sda_hist_q & sda_s;

endmodule

// File: rtl/i2c_slave_responder.sv
// I2C target: matches SLAVE_ADDR, streams write bytes out on a strobe and
// serves read bytes from a local request/valid source.
module i2c_slave_responder
   import i2c_pkg::*;
#(
   parameter logic [I2C_ADDR_W-1:0] SLAVE_ADDR  = 7'h22,
   parameter int                    SYNC_STAGES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  scl_i,
   input  logic                  sda_i,
   output logic                  sda_oe,
   output logic [I2C_DATA_W-1:0] wr_data,
   output logic                  wr_valid,
   input  logic                  wr_ready,
   output logic                  rd_req,
   input  logic [I2C_DATA_W-1:0] rd_data,
   input  logic                  rd_valid,
   output logic                  busy,
   output logic                  start_det,
   output logic                  stop_det
);

   logic scl_s, sda_s, scl_rise, scl_fall, start, stop;

   i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .scl_i    (scl_i),
      .sda_i    (sda_i),
      .scl_s    (scl_s),
      .sda_s    (sda_s),
      .scl_rise (scl_rise),
      .scl_fall (scl_fall),
      .start    (start),
      .stop     (stop)
   );

   i2c_resp_state_t       state_q, state_d;
   logic [2:0]            cnt_q, cnt_d;
   logic                  full_q, full_d;
   logic [I2C_DATA_W-1:0] sr_q, sr_d;
   logic [I2C_DATA_W-1:0] tx_q, tx_d;
   logic                  rw_q, rw_d;
   logic                  have_q, have_d;
   logic [2:0]            wait_q, wait_d;
   logic                  sda_oe_q, sda_oe_d;
   logic                  busy_q, busy_d;
   logic [I2C_DATA_W-1:0] wr_data_q, wr_data_d;
   logic                  wr_valid_q, wr_valid_d;
   logic                  rd_req_q, rd_req_d;
   logic                  start_det_q, start_det_d;
   logic                  stop_det_q, stop_det_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         full_q      <= 1'b0;
         sr_q        <= '0;
         tx_q        <= '0;
         rw_q        <= 1'b0;
         have_q      <= 1'b0;
         wait_q      <= '0;
         sda_oe_q    <= 1'b0;
         busy_q      <= 1'b0;
         wr_data_q   <= '0;
         wr_valid_q  <= 1'b0;
         rd_req_q    <= 1'b0;
         start_det_q <= 1'b0;
         stop_det_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         full_q      <= full_d;
         sr_q        <= sr_d;
         tx_q        <= tx_d;
         rw_q        <= rw_d;
         have_q      <= have_d;
         wait_q      <= wait_d;
         sda_oe_q    <= sda_oe_d;
         busy_q      <= busy_d;
         wr_data_q   <= wr_data_d;
         wr_valid_q  <= wr_valid_d;
         rd_req_q    <= rd_req_d;
         start_det_q <= start_det_d;
         stop_det_q  <= stop_det_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      full_d      = full_q;
      sr_d        = sr_q;
      tx_d        = tx_q;
      rw_d        = rw_q;
      have_d      = have_q;
      wait_d      = wait_q;
      sda_oe_d    = sda_oe_q;
      busy_d      = busy_q;
      wr_data_d   = wr_data_q;
      wr_valid_d  = 1'b0;
      rd_req_d    = 1'b0;
      start_det_d = 1'b0;
      stop_det_d  = 1'b0;

      if (start) begin
         state_d     = ADDR;
         cnt_d       = '0;
         full_d      = 1'b0;
         sda_oe_d    = 1'b0;
         start_det_d = 1'b1;
      end else if (stop) begin
         state_d    = IDLE;
         sda_oe_d   = 1'b0;
         busy_d     = 1'b0;
         stop_det_d = 1'b1;
      end else begin
         // full_q marks that the 8th bit is in; the byte is acted on at the next SCL fall
         if (scl_rise && (state_q == ADDR || state_q == WR_BYTE)) begin
            sr_d  = {sr_q[I2C_DATA_W-2:0], sda_s};
            cnt_d = cnt_q + 3'd1;
            if (cnt_q == 3'd7) full_d = 1'b1;
         end

         case (state_q)
            ADDR: begin
               if (scl_fall && full_q) begin
                  full_d = 1'b0;
                  rw_d   = sr_q[0];
                  if (sr_q[I2C_DATA_W-1:1] == SLAVE_ADDR) begin
                     state_d  = ADDR_ACK;
                     sda_oe_d = 1'b1;
                     busy_d   = 1'b1;
                  end else begin
                     state_d = IGNORE;
                     busy_d  = 1'b0;
                  end
               end
            end
            ADDR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  if (rw_q == I2C_RW_READ) begin
                     state_d  = RD_LOAD;
                     rd_req_d = 1'b1;
                     have_d   = 1'b0;
                     wait_d   = '0;
                  end else begin
                     state_d = WR_BYTE;
                     cnt_d   = '0;
                     full_d  = 1'b0;
                  end
               end
            end
            WR_BYTE: begin
               if (scl_fall && full_q) begin
                  full_d     = 1'b0;
                  wr_data_d  = sr_q;
                  wr_valid_d = wr_ready;
                  sda_oe_d   = wr_ready;
                  state_d    = WR_ACK;
               end
            end
            WR_ACK: begin
               if (scl_fall) begin
                  sda_oe_d = 1'b0;
                  state_d  = WR_BYTE;
                  cnt_d    = '0;
               end
            end
            RD_LOAD: begin
               // Entered from an ACK rise the byte waits for SCL low before bit 7 goes out
               if (!have_q) begin
                  if (rd_valid) begin
                     tx_d   = rd_data;
                     have_d = 1'b1;
                  end else if (wait_q == 3'(RD_TIMEOUT)) begin
                     tx_d   = '1;
                     have_d = 1'b1;
                  end else begin
                     wait_d = wait_q + 3'd1;
                  end
               end else if (!scl_s) begin
                  sda_oe_d = ~tx_q[I2C_DATA_W-1];
                  state_d  = RD_BYTE;
                  cnt_d    = '0;
                  have_d   = 1'b0;
               end
            end
            RD_BYTE: begin
               if (scl_fall) begin
                  if (cnt_q == 3'd7) begin
                     sda_oe_d = 1'b0;
                     state_d  = RD_ACK;
                     cnt_d    = '0;
                  end else begin
                     cnt_d    = cnt_q + 3'd1;
                     tx_d     = {tx_q[I2C_DATA_W-2:0], 1'b1};
                     sda_oe_d = ~tx_q[I2C_DATA_W-2];
                  end
               end
            end
            RD_ACK: begin
               if (scl_rise) begin
                  if (!sda_s) begin
                     state_d  = RD_LOAD;
                     rd_req_d = 1'b1;
                     have_d   = 1'b0;
                     wait_d   = '0;
                  end else begin
                     state_d = IGNORE;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign sda_oe    = sda_oe_q;
   assign wr_data   = wr_data_q;
   assign wr_valid  = wr_valid_q;
   assign rd_req    = rd_req_q;
   assign busy      = busy_q;
   assign start_det = start_det_q;
   assign stop_det  = stop_det_q;

endmodule

// File: tb/tb_i2c_slave_responder.sv
// Bench: bit-banged I2C master, read-data responder and a transfer-level reference model.
module tb_i2c_slave_responder;
   import i2c_pkg::*;

   localparam logic [6:0] SADDR = 7'h22;
   localparam int         T     = 12;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       wr_ready = 1'b1;
   logic       sda_oe, wr_valid, rd_req, busy, start_det, stop_det;
   logic [7:0] wr_data;
   logic       rd_valid;
   logic [7:0] rd_data;
   wire        sda_bus = sda_m & ~sda_oe;

   always #5 clk = ~clk;

   i2c_slave_responder #(.SLAVE_ADDR(SADDR), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .scl_i     (scl_m),
      .sda_i     (sda_bus),
      .sda_oe    (sda_oe),
      .wr_data   (wr_data),
      .wr_valid  (wr_valid),
      .wr_ready  (wr_ready),
      .rd_req    (rd_req),
      .rd_data   (rd_data),
      .rd_valid  (rd_valid),
      .busy      (busy),
      .start_det (start_det),
      .stop_det  (stop_det)
   );

   int nvec = 0;
   int nerr = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Bus monitors
   logic [7:0] wr_q[$];
   int n_rdreq = 0, n_start = 0, n_stop = 0, n_oe_bad = 0, n_busy_drop = 0;
   logic oe_prev = 1'b0;
   logic track_busy = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (wr_valid) wr_q.push_back(wr_data);
         if (rd_req) n_rdreq++;
         if (start_det) n_start++;
         if (stop_det) n_stop++;
         if (sda_oe !== oe_prev && scl_m) n_oe_bad++;
         if (track_busy && !busy) n_busy_drop++;
      end
      oe_prev = sda_oe;
   end

   // Read-data source: answers each rd_req 1..3 cycles later unless stalled
   logic [7:0] rd_src [4];
   logic       rd_stall = 1'b0;
   int         xfer_id = 0;
   int         rsp_id = 0, rsp_idx = 0, rsp_cnt = 0;

   always @(negedge clk) begin
      rd_valid = 1'b0;
      if (rsp_id != xfer_id) begin
         rsp_id  = xfer_id;
         rsp_idx = 0;
         rsp_cnt = 0;
      end
      if (rsp_cnt > 0) begin
         rsp_cnt--;
         if (rsp_cnt == 0) begin
            rd_valid = 1'b1;
            rd_data  = rd_src[rsp_idx % 4];
            rsp_idx++;
         end
      end
      if (rd_req && !rd_stall) rsp_cnt = $urandom_range(1, 3);
   end

   // Master bit-bang primitives
   task automatic w(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic bus_bit(input logic b, output logic r);
      w(T); sda_m = b;
      w(T); scl_m = 1'b1;
      w(T); r = sda_bus;
      w(T); scl_m = 1'b0;
   endtask

   task automatic bus_start();
      if (!scl_m) begin
         w(T); sda_m = 1'b1;
         w(T); scl_m = 1'b1;
      end
      w(T); sda_m = 1'b0;
      w(T); scl_m = 1'b0;
   endtask

   task automatic bus_stop();
      w(T); sda_m = 1'b0;
      w(T); scl_m = 1'b1;
      w(T); sda_m = 1'b1;
      w(T);
   endtask

   task automatic bus_byte(input logic [7:0] tx, input logic ackb,
                           output logic [7:0] rx, output logic ack_r);
      logic r;
      for (int i = 7; i >= 0; i--) begin
         bus_bit(tx[i], r);
         rx[i] = r;
      end
      bus_bit(ackb, ack_r);
   endtask

   // Transfer description and its expected outcome
   typedef struct {
      logic [6:0]      addr;
      logic            rw;
      int              n;
      logic [2:0][7:0] d;
      logic [2:0]      rdy;
      logic            stall;
   } xfer_t;

   typedef struct {
      logic            aack;
      logic [2:0]      ack;
      logic [2:0][7:0] rx;
      int              nwr;
      int              nrdreq;
   } exp_t;

   typedef struct {
      string name;
      xfer_t x;
      exp_t  e;
   } vec_t;

   function automatic xfer_t mk(logic [6:0] a, logic rw, int n, logic [7:0] d0, d1, d2,
                                logic [2:0] rdy, logic st);
      xfer_t x;
      x.addr = a; x.rw = rw; x.n = n; x.d = {d2, d1, d0}; x.rdy = rdy; x.stall = st;
      return x;
   endfunction

   function automatic exp_t mke(logic aa, logic [2:0] ack, logic [7:0] r0, r1, int nwr, int nrd);
      exp_t e;
      e.aack = aa; e.ack = ack; e.rx = {8'hFF, r1, r0}; e.nwr = nwr; e.nrdreq = nrd;
      return e;
   endfunction

   // Reference: what an addressed/unaddressed target must do for a whole transfer
   function automatic exp_t model(xfer_t x);
      exp_t e;
      logic m;
      m = (x.addr == SADDR);
      e.aack = m; e.ack = '0; e.rx = '1; e.nwr = 0; e.nrdreq = 0;
      for (int i = 0; i < x.n; i++) begin
         if (x.rw == I2C_RW_WRITE) begin
            e.ack[i] = m && x.rdy[i];
            if (e.ack[i]) e.nwr++;
         end else begin
            e.rx[i] = (m && !x.stall) ? x.d[i] : 8'hFF;
         end
      end
      if (m && x.rw == I2C_RW_READ) e.nrdreq = x.n;
      return e;
   endfunction

   task automatic run_xfer(input string tag, input xfer_t x, input exp_t e);
      int s0, p0, q0, w0, idx;
      logic [7:0] rx;
      logic a;
      s0 = n_start; p0 = n_stop; q0 = n_rdreq; w0 = wr_q.size();
      xfer_id++;
      for (int i = 0; i < 3; i++) rd_src[i] = x.d[i];
      rd_stall = x.stall;
      wr_ready = 1'b1;
      bus_start();
      bus_byte({x.addr, x.rw}, 1'b1, rx, a);
      chk({tag, " addr_ack"}, 32'(!a), 32'(e.aack));
      for (int i = 0; i < x.n; i++) begin
         if (x.rw == I2C_RW_WRITE) begin
            wr_ready = x.rdy[i];
            bus_byte(x.d[i], 1'b1, rx, a);
            chk({tag, " data_ack"}, 32'(!a), 32'(e.ack[i]));
         end else begin
            bus_byte(8'hFF, (i == x.n - 1), rx, a);
            chk({tag, " rd_byte"}, 32'(rx), 32'(e.rx[i]));
         end
      end
      bus_stop();
      w(4);
      wr_ready = 1'b1;
      chk({tag, " wr_count"}, 32'(wr_q.size() - w0), 32'(e.nwr));
      idx = w0;
      for (int i = 0; i < x.n; i++) begin
         if (x.rw == I2C_RW_WRITE && e.ack[i] && idx < wr_q.size()) begin
            chk({tag, " wr_data"}, 32'(wr_q[idx]), 32'(x.d[i]));
            idx++;
         end
      end
      chk({tag, " rd_req_count"}, 32'(n_rdreq - q0), 32'(e.nrdreq));
      chk({tag, " start_det"}, 32'(n_start - s0), 32'd1);
      chk({tag, " stop_det"}, 32'(n_stop - p0), 32'd1);
      chk({tag, " busy_after_stop"}, 32'(busy), 32'd0);
      chk({tag, " sda_released"}, 32'(sda_oe), 32'd0);
   endtask

   vec_t tbl[6];

   initial begin
      logic [7:0] rx;
      logic       a, r;
      int         s0, w0, b0;
      xfer_t      xr;

      tbl[0] = '{"wr22",    mk(7'h22, 1'b0, 2, 8'hA5, 8'h3C, 8'h00, 3'b111, 1'b0), mke(1'b1, 3'b011, 8'hFF, 8'hFF, 2, 0)};
      tbl[1] = '{"wr23",    mk(7'h23, 1'b0, 2, 8'h11, 8'h22, 8'h00, 3'b111, 1'b0), mke(1'b0, 3'b000, 8'hFF, 8'hFF, 0, 0)};
      tbl[2] = '{"rd22",    mk(7'h22, 1'b1, 2, 8'h5A, 8'h81, 8'h00, 3'b111, 1'b0), mke(1'b1, 3'b000, 8'h5A, 8'h81, 0, 2)};
      tbl[3] = '{"wr_nack", mk(7'h22, 1'b0, 2, 8'h77, 8'h99, 8'h00, 3'b001, 1'b0), mke(1'b1, 3'b001, 8'hFF, 8'hFF, 1, 0)};
      tbl[4] = '{"rd_tmo",  mk(7'h22, 1'b1, 1, 8'hC3, 8'h00, 8'h00, 3'b111, 1'b1), mke(1'b1, 3'b000, 8'hFF, 8'hFF, 0, 1)};
      tbl[5] = '{"rd23",    mk(7'h23, 1'b1, 1, 8'h12, 8'h00, 8'h00, 3'b111, 1'b0), mke(1'b0, 3'b000, 8'hFF, 8'hFF, 0, 0)};

      w(3);
      chk("reset outputs", 32'({sda_oe, wr_valid, rd_req, busy, start_det, stop_det, wr_data}), 32'd0);
      rst_n = 1'b1;
      w(5);

      for (int i = 0; i < 6; i++) run_xfer(tbl[i].name, tbl[i].x, tbl[i].e);

      // Repeated START from a write into a read
      xfer_id++;
      rd_src[0] = 8'h6E; rd_stall = 1'b0; wr_ready = 1'b1;
      s0 = n_start; w0 = wr_q.size(); b0 = n_busy_drop;
      bus_start();
      bus_byte({SADDR, I2C_RW_WRITE}, 1'b1, rx, a);
      chk("sr addr_w ack", 32'(!a), 32'd1);
      bus_byte(8'h10, 1'b1, rx, a);
      chk("sr data ack", 32'(!a), 32'd1);
      track_busy = 1'b1;
      bus_start();
      bus_byte({SADDR, I2C_RW_READ}, 1'b1, rx, a);
      track_busy = 1'b0;
      chk("sr addr_r ack", 32'(!a), 32'd1);
      bus_byte(8'hFF, 1'b1, rx, a);
      chk("sr rd_byte", 32'(rx), 32'h6E);
      bus_stop();
      w(4);
      chk("sr start_det", 32'(n_start - s0), 32'd2);
      chk("sr busy held", 32'(n_busy_drop - b0), 32'd0);
      chk("sr wr_count", 32'(wr_q.size() - w0), 32'd1);
      if (wr_q.size() > w0) chk("sr wr_data", 32'(wr_q[w0]), 32'h10);

      // Asynchronous reset while the target drives a 0 data bit
      xfer_id++;
      rd_src[0] = 8'h00; rd_stall = 1'b0;
      bus_start();
      bus_byte({SADDR, I2C_RW_READ}, 1'b1, rx, a);
      chk("rst addr ack", 32'(!a), 32'd1);
      bus_bit(1'b1, r);
      w(T);
      chk("rst oe before", 32'(sda_oe), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst oe async", 32'(sda_oe), 32'd0);
      chk("rst busy", 32'(busy), 32'd0);
      chk("rst state idle", 32'(dut.state_q == IDLE), 32'd1);
      w(3);
      rst_n = 1'b1;
      sda_m = 1'b1;
      w(T); scl_m = 1'b1;
      w(T);
      run_xfer("post_rst", mk(SADDR, 1'b0, 1, 8'h5C, 8'h00, 8'h00, 3'b111, 1'b0),
               mke(1'b1, 3'b001, 8'hFF, 8'hFF, 1, 0));

      // Random transfers against the reference model
      for (int k = 0; k < 10; k++) begin
         xr = mk(($urandom_range(0, 2) == 0) ? 7'($urandom_range(0, 127)) : SADDR,
                 1'($urandom_range(0, 1)), $urandom_range(1, 3),
                 8'($urandom), 8'($urandom), 8'($urandom),
                 3'($urandom_range(0, 7)), 1'b0);
         run_xfer("rand", xr, model(xr));
      end

      chk("sda_oe stable while SCL high", 32'(n_oe_bad), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
